data_memory: RTL and testbench



---
 rtl/data_memory_pkg.sv | 10 +
 rtl/data_memory.sv | 50 +++++
 tb/tb_data_memory.sv | 130 +++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared definitions for the MEM-stage data memory and the pipeline registers
// that carry its words.
package data_memory_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;

  typedef logic [DATA_W-1:0] word_t;

endpackage : data_memory_pkg

// File: rtl/data_memory.sv
// Word-indexed data memory: synchronous write and whole-array clear,
// combinational read gated by MemRead.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W = data_memory_pkg::DATA_W,
  parameter int DEPTH  = data_memory_pkg::DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [31:0]       read_address,
  input  logic [DATA_W-1:0] Write_data,
  output logic [DATA_W-1:0] MemData_out
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] index_s;
  logic              unused_addr_s;

  // Upper address bits are dropped on purpose so addresses alias modulo DEPTH.
  assign index_s       = read_address[ADDR_W-1:0];
  assign unused_addr_s = ^read_address[31:ADDR_W];

  // Storage update: reset clears every word and takes priority over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (MemWrite) begin
      mem_q[index_s] <= Write_data;
    end else begin
      mem_q[index_s] <= mem_q[index_s];
    end
  end

  // Zero-latency read; held at zero while not reading or while in reset.
  always_comb begin
    MemData_out = '0;
    if (MemRead && !reset) begin
      MemData_out = mem_q[index_s];
    end else begin
      MemData_out = '0;
    end
  end

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: reset clear, write/read-back,
// read gating, same-cycle read/write, address aliasing and reset-over-write.
module tb_data_memory;
  import data_memory_pkg::*;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] read_address;
  word_t       Write_data;
  word_t       MemData_out;

  int checks = 0;
  int errors = 0;

  data_memory dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .read_address (read_address),
    .Write_data   (Write_data),
    .MemData_out  (MemData_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_word(input string tag, input word_t obs, input word_t exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] addr, input word_t data);
    read_address = addr;
    Write_data   = data;
    MemWrite     = 1'b1;
    tick();
    MemWrite     = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input word_t exp);
    read_address = addr;
    MemRead      = 1'b1;
    #1;
    check_word(tag, MemData_out, exp);
  endtask

  initial begin
    reset        = 1'b1;
    MemWrite     = 1'b0;
    MemRead      = 1'b1;
    read_address = 32'd0;
    Write_data   = 32'h0;

    tick();
    tick();
    check_word("out_in_reset", MemData_out, 32'h0000_0000);
    reset = 1'b0;
    read_check("post_reset_a0", 32'd0, 32'h0000_0000);

    MemRead = 1'b0;
    write_word(32'd10, 32'hDEAD_BEEF);
    read_check("rd_a10", 32'd10, 32'hDEAD_BEEF);

    MemRead = 1'b0;
    write_word(32'd20, 32'h1234_5678);
    read_check("rd_a20", 32'd20, 32'h1234_5678);
    read_check("rd_a10_kept", 32'd10, 32'hDEAD_BEEF);
    read_check("rd_a30_unwritten", 32'd30, 32'h0000_0000);

    read_address = 32'd20;
    MemRead      = 1'b0;
    #1;
    check_word("rd_gated", MemData_out, 32'h0000_0000);

    // Read and write together: old word before the edge, new word after it.
    read_address = 32'd40;
    MemRead      = 1'b1;
    Write_data   = 32'h1111_2222;
    MemWrite     = 1'b1;
    #1;
    check_word("rw_before_edge", MemData_out, 32'h0000_0000);
    tick();
    MemWrite = 1'b0;
    check_word("rw_after_edge", MemData_out, 32'h1111_2222);

    write_word(32'd10, 32'hCAFE_F00D);
    read_check("rd_a10_overwrite", 32'd10, 32'hCAFE_F00D);

    write_word(32'd261, 32'hA5A5_A5A5);
    read_check("alias_a5", 32'd5, 32'hA5A5_A5A5);
    write_word(32'd7, 32'h0F0F_0F0F);
    read_check("alias_a263", 32'd263, 32'h0F0F_0F0F);
    read_check("alias_hi_bits", 32'hFFFF_FF07, 32'h0F0F_0F0F);

    // Reset overrides a write in the same cycle and clears the array.
    read_address = 32'd50;
    Write_data   = 32'h7777_8888;
    MemWrite     = 1'b1;
    MemRead      = 1'b1;
    reset        = 1'b1;
    #1;
    check_word("out_reset_high", MemData_out, 32'h0000_0000);
    tick();
    reset    = 1'b0;
    MemWrite = 1'b0;
    read_check("rst_drops_write", 32'd50, 32'h0000_0000);
    read_check("rst_clears_a10", 32'd10, 32'h0000_0000);
    read_check("rst_clears_a5", 32'd5, 32'h0000_0000);
    read_check("rst_clears_a255", 32'd255, 32'h0000_0000);

    write_word(32'd255, 32'h8000_0001);
    read_check("rd_top_word", 32'd255, 32'h8000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_data_memory
